// File: rtl/calc_l_multi.sv
// calc_l_multi: per-channel drive-level calculator with a d-edge kick followed by BOOST/CUT pre-emphasis.
// Optional feature macro: CALC_L_KICK_EN adds the KICK state and hold counter; undefined, edges go straight to EMPH.
module calc_l_multi #(
   parameter int NCH    = 4,
   parameter int W      = 12,
   parameter int LMAX   = 500,
   parameter int HOLD_W = 20
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              data_start,
   input  logic              data_trans,
   input  logic              data_rec,
   input  logic [HOLD_W-1:0] hold_cyc,
   input  logic [NCH*W-1:0]  l_def,
   input  logic [NCH-1:0]    d,
   output logic [NCH*W-1:0]  l,
   output logic [NCH*2-1:0]  phase
);
   localparam int WX = W + 2;
   localparam logic [WX-1:0] LMAX_X = WX'(LMAX);
   localparam logic [W-1:0]  LMAX_W = W'(LMAX);

   typedef enum logic [1:0] {IDLE = 2'b00, KICK = 2'b01, EMPH = 2'b10} state_t;

   function automatic logic [WX-1:0] f_clamp(input logic [W-1:0] v);
      logic [WX-1:0] vx;
      vx = WX'(v);
      if (vx > LMAX_X) f_clamp = LMAX_X;
      else             f_clamp = vx;
   endfunction

   // First of lc + lc/k (k = 2,3,4,5,10) strictly below full scale
   function automatic logic [WX-1:0] f_boost(input logic [WX-1:0] lc);
      logic [WX-1:0] c2, c3, c4, c5, c10;
      c2  = lc + lc / WX'(2);
      c3  = lc + lc / WX'(3);
      c4  = lc + lc / WX'(4);
      c5  = lc + lc / WX'(5);
      c10 = lc + lc / WX'(10);
      if      (c2  < LMAX_X) f_boost = c2;
      else if (c3  < LMAX_X) f_boost = c3;
      else if (c4  < LMAX_X) f_boost = c4;
      else if (c5  < LMAX_X) f_boost = c5;
      else if (c10 < LMAX_X) f_boost = c10;
      else                   f_boost = LMAX_X;
   endfunction

   function automatic logic [WX-1:0] f_cut(input logic [WX-1:0] lc);
      if ((LMAX_X - lc) < (lc / WX'(5))) f_cut = (lc + lc) - LMAX_X;
      else                               f_cut = lc / WX'(3);
   endfunction

   logic w_act;
   logic w_kick_ok;
   assign w_act = data_start & data_trans & ~data_rec;

`ifdef CALC_L_KICK_EN
   assign w_kick_ok = (hold_cyc != {HOLD_W{1'b0}});
`else
   logic w_unused_hold;
   assign w_kick_ok     = 1'b0;
   assign w_unused_hold = ^hold_cyc;
`endif

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         logic          r_s1, r_ds, r_dp;
         state_t        r_state, w_state_nxt;
         logic [W-1:0]  r_l, w_l_nxt, w_emph;
         logic [WX-1:0] w_lc;
         logic          w_edge, w_rise, w_cnt_last;

         assign w_lc   = f_clamp(l_def[g*W +: W]);
         assign w_emph = r_ds ? W'(f_boost(w_lc)) : W'(f_cut(w_lc));
         assign w_edge = r_ds ^ r_dp;
         assign w_rise = r_ds & ~r_dp;

         // Synchroniser, edge history, FSM state and registered drive level
         always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
               r_s1    <= 1'b0;
               r_ds    <= 1'b0;
               r_dp    <= 1'b0;
               r_state <= IDLE;
               r_l     <= {W{1'b0}};
            end else begin
               r_s1    <= d[g];
               r_ds    <= r_s1;
               r_dp    <= r_ds;
               r_state <= w_state_nxt;
               r_l     <= w_l_nxt;
            end
         end

         // Next state and level; an edge with a nonzero hold always (re)starts a kick
         always_comb begin
            w_state_nxt = r_state;
            w_l_nxt     = r_l;
            if (!w_act) begin
               w_state_nxt = IDLE;
               if (data_start) w_l_nxt = w_lc[W-1:0];
               else            w_l_nxt = r_l;
            end else if (w_edge && w_kick_ok) begin
               w_state_nxt = KICK;
               w_l_nxt     = w_rise ? LMAX_W : {W{1'b0}};
            end else begin
               case (r_state)
                  KICK: begin
                     if (w_edge || w_cnt_last) begin
                        w_state_nxt = EMPH;
                        w_l_nxt     = w_emph;
                     end else begin
                        w_state_nxt = KICK;
                        w_l_nxt     = r_l;
                     end
                  end
                  IDLE, EMPH: begin
                     w_state_nxt = EMPH;
                     w_l_nxt     = w_emph;
                  end
                  default: begin
                     w_state_nxt = IDLE;
                     w_l_nxt     = r_l;
                  end
               endcase
            end
         end

`ifdef CALC_L_KICK_EN
         logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
         assign w_cnt_last = (r_cnt == {{(HOLD_W-1){1'b0}}, 1'b1});

         // Hold counter: loads on the kick-starting edge, counts down while kicking
         always_comb begin
            w_cnt_nxt = {HOLD_W{1'b0}};
            if (w_act && (w_state_nxt == KICK)) begin
               if (w_edge) w_cnt_nxt = hold_cyc;
               else        w_cnt_nxt = r_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
            end else begin
               w_cnt_nxt = {HOLD_W{1'b0}};
            end
         end

         always_ff @(posedge clk or posedge nrst) begin
            if (nrst) r_cnt <= {HOLD_W{1'b0}};
            else      r_cnt <= w_cnt_nxt;
         end
`else
         assign w_cnt_last = 1'b0;
`endif

         assign l[g*W +: W]     = r_l;
         assign phase[g*2 +: 2] = r_state;
      end
   endgenerate
endmodule

// File: tb/tb_calc_l_multi.sv
// Testbench for calc_l_multi: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model of the level rules.
module tb_calc_l_multi;
   localparam int NCH    = 4;
   localparam int W      = 12;
   localparam int LMAX   = 500;
   localparam int HOLD_W = 20;
`ifdef CALC_L_KICK_EN
   localparam bit KICK_EN = 1'b1;
`else
   localparam bit KICK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              nrst;
   logic              data_start, data_trans, data_rec;
   logic [HOLD_W-1:0] hold_cyc;
   logic [NCH*W-1:0]  l_def;
   logic [NCH-1:0]    d;
   logic [NCH*W-1:0]  l;
   logic [NCH*2-1:0]  phase;

   int n_assert = 0;
   int n_fail   = 0;

   calc_l_multi #(.NCH(NCH), .W(W), .LMAX(LMAX), .HOLD_W(HOLD_W)) dut (
      .clk(clk), .nrst(nrst), .data_start(data_start), .data_trans(data_trans),
      .data_rec(data_rec), .hold_cyc(hold_cyc), .l_def(l_def), .d(d),
      .l(l), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int c, input int a, input int e);
      n_assert++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", nm, c, a, e, $time);
      end
   endtask

   function automatic int dut_l(input int c);
      return int'(l[c*W +: W]);
   endfunction

   function automatic int dut_ph(input int c);
      return int'(phase[c*2 +: 2]);
   endfunction

   task automatic set_ldef(input int c, input int v);
      l_def[c*W +: W] = W'(v);
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int m_boost(input int lc);
      int ks[5] = '{2, 3, 4, 5, 10};
      for (int i = 0; i < 5; i++)
         if (lc + lc / ks[i] < LMAX) return lc + lc / ks[i];
      return LMAX;
   endfunction

   function automatic int m_cut(input int lc);
      if (LMAX - lc < lc / 5) return 2 * lc - LMAX;
      return lc / 3;
   endfunction

   // Behavioural model: m_h holds the last three sampled d values (bit 0 newest)
   int       m_l[NCH], m_ph[NCH], m_left[NCH];
   bit [2:0] m_h[NCH];
   int       md_s, md_p, m_lc, m_em;
   bit       m_act, m_edge, m_kick;

   always @(posedge clk or posedge nrst) begin
      if (nrst) begin
         for (int c = 0; c < NCH; c++) begin
            m_l[c] = 0; m_ph[c] = 0; m_left[c] = 0; m_h[c] = 3'b000;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            md_s   = int'(m_h[c][1]);
            md_p   = int'(m_h[c][2]);
            m_lc   = int'(l_def[c*W +: W]);
            if (m_lc > LMAX) m_lc = LMAX;
            m_em   = (md_s == 1) ? m_boost(m_lc) : m_cut(m_lc);
            m_act  = data_start && data_trans && !data_rec;
            m_edge = (md_s != md_p);
            m_kick = KICK_EN && (hold_cyc != 0);
            if (!m_act) begin
               m_ph[c] = 0; m_left[c] = 0;
               if (data_start) m_l[c] = m_lc;
            end else if (m_edge && m_kick) begin
               m_ph[c] = 1; m_left[c] = int'(hold_cyc);
               m_l[c] = (md_s == 1) ? LMAX : 0;
            end else if (m_ph[c] == 1 && !m_edge) begin
               m_left[c]--;
               if (m_left[c] == 0) begin m_ph[c] = 2; m_l[c] = m_em; end
            end else begin
               m_ph[c] = 2; m_left[c] = 0; m_l[c] = m_em;
            end
            m_h[c] = {m_h[c][1:0], d[c]};
         end
      end
   end

   // Cycle-by-cycle comparison of every channel against the model
   always @(posedge clk) begin
      #2;
      for (int c = 0; c < NCH; c++) begin
         chk("model_l", c, dut_l(c), m_l[c]);
         chk("model_phase", c, dut_ph(c), m_ph[c]);
      end
   end

   initial begin
      nrst = 1'b1; data_start = 1'b0; data_trans = 1'b0; data_rec = 1'b0;
      hold_cyc = 20'd4;
      l_def = 48'({$urandom(), $urandom()});
      d = 4'($urandom());
      data_start = 1'($urandom());
      wait_neg(3);
      for (int c = 0; c < NCH; c++) begin
         chk("reset_l", c, dut_l(c), 0);
         chk("reset_phase", c, dut_ph(c), 0);
      end

      nrst = 1'b0; d = 4'b0000; data_start = 1'b1; data_trans = 1'b0; data_rec = 1'b0;
      set_ldef(0, 200); set_ldef(1, 400); set_ldef(2, 450); set_ldef(3, 4000);
      wait_neg(1);
      chk("idle_lc", 0, dut_l(0), 200);
      chk("idle_lc_clamp", 3, dut_l(3), 500);

      data_trans = 1'b1;
      wait_neg(2);
      chk("cut", 0, dut_l(0), 66);
      chk("cut", 1, dut_l(1), 133);
      chk("cut", 2, dut_l(2), 400);
      chk("cut", 3, dut_l(3), 500);
      chk("emph_phase", 0, dut_ph(0), 2);

`ifdef CALC_L_KICK_EN
      d = 4'b1111;
      wait_neg(3);
      chk("kick_hi_start", 0, dut_l(0), 500);
      chk("kick_phase", 0, dut_ph(0), 1);
      wait_neg(3);
      chk("kick_hi_end", 0, dut_l(0), 500);
      wait_neg(1);
      chk("boost", 0, dut_l(0), 300);
      chk("boost", 1, dut_l(1), 480);
      chk("boost", 2, dut_l(2), 495);
      chk("boost", 3, dut_l(3), 500);
      chk("boost_phase", 0, dut_ph(0), 2);
      d = 4'b0000;
      wait_neg(3);
      chk("kick_lo_start", 0, dut_l(0), 0);
      wait_neg(4);
      chk("kick_lo_then_cut", 0, dut_l(0), 66);

      d[0] = 1'b1;
      wait_neg(2);
      d[0] = 1'b0;
      wait_neg(2);
      chk("rekick_hi", 0, dut_l(0), 500);
      wait_neg(1);
      chk("rekick_lo_start", 0, dut_l(0), 0);
      wait_neg(3);
      chk("rekick_lo_end", 0, dut_l(0), 0);
      wait_neg(1);
      chk("rekick_cut", 0, dut_l(0), 66);

      hold_cyc = 20'd0; d[0] = 1'b1;
      wait_neg(3);
      chk("hold0_boost", 0, dut_l(0), 300);
      chk("hold0_phase", 0, dut_ph(0), 2);
      d[0] = 1'b0;
      wait_neg(3);
      chk("hold0_cut", 0, dut_l(0), 66);

      hold_cyc = 20'd4; d[0] = 1'b1;
      wait_neg(3);
      chk("rec_pre_phase", 0, dut_ph(0), 1);
      data_rec = 1'b1;
      wait_neg(1);
      chk("rec_phase", 0, dut_ph(0), 0);
      chk("rec_l", 0, dut_l(0), 200);
      data_start = 1'b0;
      wait_neg(2);
      chk("nostart_hold", 0, dut_l(0), 200);
      data_start = 1'b1; data_rec = 1'b0;
      wait_neg(3);
      chk("resume_boost", 0, dut_l(0), 300);
`else
      d = 4'b1111;
      wait_neg(3);
      chk("nk_boost", 0, dut_l(0), 300);
      chk("nk_boost", 1, dut_l(1), 480);
      chk("nk_boost", 2, dut_l(2), 495);
      chk("nk_boost", 3, dut_l(3), 500);
      chk("nk_phase", 0, dut_ph(0), 2);
      d = 4'b0000;
      wait_neg(3);
      chk("nk_cut", 0, dut_l(0), 66);
      chk("nk_phase", 0, dut_ph(0), 2);
`endif

      chk("pre_reset_phase", 0, dut_ph(0), 2);
      @(posedge clk);
      #3;
      nrst = 1'b1;
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk("async_reset_l", c, dut_l(c), 0);
         chk("async_reset_phase", c, dut_ph(c), 0);
      end
      @(negedge clk);
      nrst = 1'b0;

`ifdef CALC_L_KICK_EN
      wait_neg(4);
      hold_cyc = {HOLD_W{1'b1}}; d[1] = ~d[1];
      wait_neg(3);
      chk("maxhold_phase", 1, dut_ph(1), 1);
      wait_neg(40);
      chk("maxhold_still_kick", 1, dut_ph(1), 1);
      hold_cyc = 20'd4;
`endif

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) begin
            data_start = ($urandom_range(0, 7) != 0);
            data_trans = ($urandom_range(0, 7) != 0);
            data_rec   = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 31) == 0) hold_cyc = HOLD_W'($urandom_range(0, 6));
         if ($urandom_range(0, 19) == 0)
            set_ldef(int'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(380, 520))
                                                 : int'($urandom_range(0, 4095)));
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 4) == 0) d[c] = ~d[c];
      end

      wait_neg(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/calc_l_multi.md
# calc_l_multi

Multi-channel, parametrised successor to the single-channel drive-level calculator in the transmit path. Per channel, it turns a default level `l_def` and a data bit `d` into a registered drive level `l`. Each `d` edge starts a full-scale kick (`LMAX` or 0) lasting a programmable number of cycles. A steady-state pre-emphasis level follows the kick. Unlike its predecessor, `d` is synchronised and edge-detected inside the `clk` domain, the hold length is a runtime input, and the state is observable. It sits between the framing logic and the per-channel PWM drivers.

## Interface
- `NCH`, 4: number of independent channels.
- `W`, 12: level width, for `l_def` and `l`.
- `LMAX`, 500: full-scale level; must be < 2^W.
- `HOLD_W`, 20: width of the hold counter and of `hold_cyc`.
- `clk` in 1: single clock, all logic on the rising edge.
- `nrst` in 1: reset, asynchronous and active-high (1 = reset).
- `data_start` in 1: frame enable, shared by all channels.
- `data_trans` in 1: transmit phase active, shared.
- `data_rec` in 1: receive phase active, shared.
- `hold_cyc` in `HOLD_W`: kick duration in clk cycles, sampled at each edge.
- `l_def` in `NCH*W`: per-channel default level; channel i is in bits [i*W +: W].
- `d` in `NCH`: per-channel data bit, asynchronous to `clk`.
- `l` out `NCH*W`: per-channel registered drive level.
- `phase` out `NCH*2`: per-channel state, 00 IDLE, 01 KICK, 10 EMPH.

## Operation
- Active condition `act = data_start & data_trans & ~data_rec`.
- Per channel, `d` passes through a 2-flop synchroniser giving `ds`, then a 1-flop history `dp`.
  - rise = `ds & ~dp`; fall = `~ds & dp`.
- Clamp: `lc = min(l_def, LMAX)`. All arithmetic is done in W+2 bits and is unsigned. Division is integer with truncation.
- BOOST is the first of `lc + lc/k`, for k = 2, 3, 4, 5, 10, that is strictly less than `LMAX`. If none qualifies, BOOST = `LMAX`.
- CUT = `2*lc - LMAX` if `(LMAX - lc) < lc/5`, else `lc/3`.
- State machine, per channel:
  - **IDLE**
    - If `act` and an edge is seen with `hold_cyc != 0`, go to KICK. The counter loads `hold_cyc`. `l` = `LMAX` on rise, 0 on fall.
    - If `act` and an edge is seen with `hold_cyc == 0`, go to EMPH.
    - If `act` and no edge is seen, go to EMPH using the current `ds`.
    - If not `act`: `l <= lc` when `data_start=1`; otherwise `l` holds.
  - **KICK**
    - The counter decrements each cycle.
    - When the counter = 1, go to EMPH on the next edge.
    - A new edge restarts KICK with the new polarity and a reloaded counter. If `hold_cyc=0`, that edge goes straight to EMPH instead.
  - **EMPH**
    - `l` = BOOST while `ds=1`, CUT while `ds=0`. `l` tracks `l_def` changes with 1-cycle latency.
    - An edge goes to KICK (or stays in EMPH if `hold_cyc=0`).
  - **Any state with `act`=0**: go to IDLE on the next edge and clear the counter.
- Channels are fully independent. Only the mode inputs and `hold_cyc` are shared.

## Timing
- Reset values: `l` = 0 for all channels, `phase` = 00, counters 0, synchroniser and `dp` flops 0.
- Deassertion of `nrst` is synchronised externally.
- Latency from `d` change to `l` change is 3 rising edges: edge 1 samples the new `d`, edges 2 and 3 move it through `ds` and the edge detector, and `l` and `phase` update on edge 3.
- Pulses of `d` shorter than 2 clk cycles may be lost; this is allowed.
- KICK lasts exactly `hold_cyc` cycles of `l` at `LMAX`/0. `hold_cyc = 2^HOLD_W - 1` is legal and has no wrap.
- An edge arriving in the same cycle that the counter = 1 means the edge wins and the kick restarts.
- `act` falling mid-KICK: `l` = `lc` on the next edge if `data_start=1`, else `l` holds the kick value.
- Reset mid-operation returns everything to reset values immediately, asynchronously.

## Configuration
- `CALC_L_KICK_EN` defined: KICK state and hold counter are present, behaving as above.
- `CALC_L_KICK_EN` undefined:
  - No counter, `hold_cyc` is ignored, and `phase` never reads 01.
  - Every edge goes directly to EMPH.
  - Latency is still 3 edges.

## Test plan
All scenarios use `NCH=4`, `W=12`, `LMAX=500`, `hold_cyc=4`, and `act=1` unless stated.
- Reset with `nrst=1` and random inputs -> all `l`=0 and `phase`=00; after release with `act=0` and `data_start=1`, `l_def=200` -> `l`=200 one cycle later.
- Channel 0 with `l_def=200`, `d` 0->1 -> 3 edges later `l`=500 for 4 cycles, then 300; then `d` 1->0 -> `l`=0 for 4 cycles, then 66.
- Channel 1 with `l_def=400` -> BOOST 480, CUT 133; channel 2 with `l_def=450` -> BOOST 495, CUT 400; channel 3 with `l_def=4000` -> clamped to 500, BOOST 500, CUT 500.
- Re-edge mid-kick: `d` rises, then falls 2 cycles into the kick -> `l`=0 for a full 4 cycles, then CUT. Set `hold_cyc=0` -> the edge goes straight to BOOST or CUT.
- `data_rec=1` mid-KICK -> `phase`=00 and `l`=`lc` next cycle. Then drop `data_start` -> `l` holds. Assert `nrst` mid-EMPH -> `l`=0 asynchronously.
- Build without `CALC_L_KICK_EN` -> a `d` rise gives BOOST directly after 3 edges, and `phase` never reads 01.
